// File: rtl/src2_sequencer.sv
// Operand-2 front end: decodes the ARM shifter form, fetches Rm/Rs over one
// shared register-file read port, and holds the bundle until the consumer takes it.
module src2_sequencer #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic             rf_re,
    output logic [RA_W-1:0]  rf_ra,
    input  logic [31:0]      rf_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       op_state,
    output logic [23:0]      imm24,
    output logic [31:0]      rm_val,
    output logic [31:0]      rs_val,
    output logic             rrx,
    output logic             illegal,
    output logic [CNT_W-1:0] issued
);

    typedef enum logic [1:0] {IDLE, RD_RM, RD_RS, ISSUE} state_t;

    localparam logic [3:0] OP_ROTIMM8 = 4'd0;
    localparam logic [3:0] OP_SHAMT5  = 4'd1;
    localparam logic [3:0] OP_RSSHIFT = 4'd5;
    localparam logic [3:0] OP_IMM12   = 4'd9;
    localparam logic [3:0] OP_BRANCH  = 4'd10;
    localparam logic [3:0] OP_DIRRM   = 4'd11;

    state_t state, state_nx;

    logic [RA_W-1:0] rm_addr, rs_addr;
    logic            need_rs;

    logic [3:0] dec_op;
    logic       dec_rrx, dec_ill, dec_rm, dec_rs;
    logic [1:0] sh;
    logic [4:0] sa;
    logic       unused_cond;

    assign sh          = instr[6:5];
    assign sa          = instr[11:7];
    assign unused_cond = ^instr[31:28];

    always_comb begin
        dec_op  = OP_ROTIMM8;
        dec_rrx = 1'b0;
        dec_ill = 1'b0;
        dec_rm  = 1'b0;
        dec_rs  = 1'b0;
        case (instr[27:26])
            2'b00, 2'b01: begin
                if (instr[27:26] == 2'b00 && instr[25]) begin
                    dec_op = OP_ROTIMM8;
                end else if (instr[27:26] == 2'b01 && !instr[25]) begin
                    dec_op = OP_IMM12;
                end else if (instr[27:26] == 2'b00 && instr[4]) begin
                    dec_rm = 1'b1;
                    dec_rs = 1'b1;
                    dec_op = OP_RSSHIFT + {2'b00, sh};
                end else begin
                    // Shift-by-zero must bypass the shifter, which would otherwise hold its last output
                    dec_rm = 1'b1;
                    if (sa == 5'd0) begin
                        dec_op  = OP_DIRRM;
                        dec_rrx = (sh == 2'b11);
                    end else begin
                        dec_op = OP_SHAMT5 + {2'b00, sh};
                    end
                end
            end
            2'b10: dec_op = OP_BRANCH;
            default: begin
                dec_op  = OP_DIRRM;
                dec_ill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        out_valid   = 1'b0;
        rf_re       = 1'b0;
        rf_ra       = '0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nx = dec_rm ? RD_RM : ISSUE;
            end
            RD_RM: begin
                rf_re    = 1'b1;
                rf_ra    = rm_addr;
                state_nx = need_rs ? RD_RS : ISSUE;
            end
            RD_RS: begin
                rf_re    = 1'b1;
                rf_ra    = rs_addr;
                state_nx = ISSUE;
            end
            ISSUE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rm_addr  <= '0;
            rs_addr  <= '0;
            need_rs  <= 1'b0;
            op_state <= '0;
            imm24    <= '0;
            rm_val   <= '0;
            rs_val   <= '0;
            rrx      <= 1'b0;
            illegal  <= 1'b0;
            issued   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        rm_addr  <= RA_W'(instr[3:0]);
                        rs_addr  <= RA_W'(instr[11:8]);
                        need_rs  <= dec_rs;
                        op_state <= dec_op;
                        imm24    <= instr[23:0];
                        rm_val   <= '0;
                        rs_val   <= '0;
                        rrx      <= dec_rrx;
                        illegal  <= dec_ill;
                    end
                end
                RD_RM: rm_val <= rf_rd;
                RD_RS: begin
                    rs_val <= {24'b0, rf_rd[7:0]};
                    if (rf_rd[7:0] == 8'd0) op_state <= OP_DIRRM;
                end
                ISSUE: begin
                    if (out_ready) issued <= issued + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
